tcm_lsu_adapter: RTL and testbench

- Load/store adapter between the core data-side LSU and port B of the dual-port TCM; it drives the TCM's address, request, write enable, byte-enable and write-data inputs and consumes its grant, valid and read data.
- Converts byte/half/word accesses into word-aligned TCM accesses: byte enables, write-lane replication, read-lane extraction with sign/zero extension.
- Flags misaligned, reserved-size and out-of-range accesses as error responses.
- Holds one transaction outstanding, with a registered response and valid/ready handshakes on both sides.

---
 rtl/tcm_lsu_adapter.sv | 162 ++++++++++++++++
 tb/tb_tcm_lsu_adapter.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tcm_lsu_adapter.sv
// LSU-to-TCM port B adapter: turns byte/half/word accesses into word-aligned TCM
// transactions, keeps one access outstanding and returns a registered response.
module tcm_lsu_adapter (
  input  logic        aclk,
  input  logic        aresetn,
  // LSU request
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_wdata,
  // LSU response
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  // TCM port B
  output logic [31:0] tcm_address,
  output logic        tcm_request,
  output logic        tcm_write_enable,
  output logic [3:0]  tcm_byte_enable,
  output logic [31:0] tcm_write_data,
  input  logic [31:0] tcm_read_data,
  input  logic        tcm_grant,
  input  logic        tcm_valid
);

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StResp
  } state_e;

  state_e      state_q;
  logic [1:0]  lane_q;
  logic [1:0]  size_q;
  logic        signed_q;
  logic        we_q;
  logic        resp_valid_q;
  logic        resp_err_q;
  logic [31:0] resp_rdata_q;

  logic        is_idle;
  logic        misaligned;
  logic [3:0]  req_be;
  logic [31:0] req_wd;
  logic [31:0] lane_word;
  logic [31:0] load_result;

  assign is_idle = (state_q == StIdle);

  assign misaligned = (req_size == 2'b01 && req_addr[0])
                   || (req_size == 2'b10 && req_addr[1:0] != 2'b00)
                   || (req_size == 2'b11);

  always_comb begin
    req_be = 4'b0000;
    req_wd = req_wdata;
    case (req_size)
      2'b00: begin
        req_be = 4'b0001 << req_addr[1:0];
        req_wd = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        req_be = req_addr[1] ? 4'b1100 : 4'b0011;
        req_wd = {2{req_wdata[15:0]}};
      end
      2'b10: begin
        req_be = 4'b1111;
        req_wd = req_wdata;
      end
      default: begin
        req_be = 4'b0000;
        req_wd = req_wdata;
      end
    endcase
  end

  // TCM side is purely combinational so a request costs no extra cycle; it is
  // only ever driven from IDLE, which keeps a single access outstanding.
  assign req_ready        = is_idle;
  assign tcm_request      = is_idle && req_valid && !misaligned;
  assign tcm_address      = is_idle ? req_addr : 32'h0;
  assign tcm_write_enable = is_idle && req_we;
  assign tcm_byte_enable  = (is_idle && req_we) ? req_be : 4'b0000;
  assign tcm_write_data   = is_idle ? req_wd : 32'h0;

  // Selected lane moved down to bits [15:0]; halves only ever use lanes 0 and 2.
  assign lane_word = tcm_read_data >> {lane_q, 3'b000};

  always_comb begin
    load_result = 32'h0;
    if (!we_q) begin
      case (size_q)
        2'b00:   load_result = {{24{signed_q & lane_word[7]}}, lane_word[7:0]};
        2'b01:   load_result = {{16{signed_q & lane_word[15]}}, lane_word[15:0]};
        default: load_result = tcm_read_data;
      endcase
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q      <= StIdle;
      lane_q       <= 2'b00;
      size_q       <= 2'b00;
      signed_q     <= 1'b0;
      we_q         <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= 32'h0;
    end else begin
      case (state_q)
        StIdle: begin
          if (req_valid) begin
            if (tcm_request && tcm_grant) begin
              lane_q   <= req_addr[1:0];
              size_q   <= req_size;
              signed_q <= req_signed;
              we_q     <= req_we;
              state_q  <= StWait;
            end else begin
              // Misaligned/reserved size, or the TCM refused the address.
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b1;
              resp_rdata_q <= 32'h0;
              state_q      <= StResp;
            end
          end
        end
        StWait: begin
          if (tcm_valid) begin
            resp_valid_q <= 1'b1;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= load_result;
            state_q      <= StResp;
          end
        end
        StResp: begin
          if (resp_ready) begin
            resp_valid_q <= 1'b0;
            state_q      <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_rdata = resp_rdata_q;

  assert property (@(posedge aclk) disable iff (!aresetn)
    tcm_request |-> is_idle);

  assert property (@(posedge aclk) disable iff (!aresetn)
    (resp_valid && !resp_ready) |=> (resp_valid && $stable(resp_rdata) && $stable(resp_err)));

endmodule

// File: tb/tb_tcm_lsu_adapter.sv
// Bench for tcm_lsu_adapter: behavioural TCM plus a byte-array reference memory;
// directed cases followed by randomized accesses.
module tb_tcm_lsu_adapter;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = 32'h0;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_signed = 1'b0;
  logic [31:0] req_wdata = 32'h0;
  logic        resp_valid;
  logic        resp_ready = 1'b1;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] tcm_address;
  logic        tcm_request;
  logic        tcm_write_enable;
  logic [3:0]  tcm_byte_enable;
  logic [31:0] tcm_write_data;
  logic [31:0] tcm_read_data;
  logic        tcm_grant;
  logic        tcm_valid;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  tcm_lsu_adapter dut (
    .aclk             (aclk),
    .aresetn          (aresetn),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_addr         (req_addr),
    .req_we           (req_we),
    .req_size         (req_size),
    .req_signed       (req_signed),
    .req_wdata        (req_wdata),
    .resp_valid       (resp_valid),
    .resp_ready       (resp_ready),
    .resp_rdata       (resp_rdata),
    .resp_err         (resp_err),
    .tcm_address      (tcm_address),
    .tcm_request      (tcm_request),
    .tcm_write_enable (tcm_write_enable),
    .tcm_byte_enable  (tcm_byte_enable),
    .tcm_write_data   (tcm_write_data),
    .tcm_read_data    (tcm_read_data),
    .tcm_grant        (tcm_grant),
    .tcm_valid        (tcm_valid)
  );

  always #5 aclk = ~aclk;
  always @(posedge aclk) cyc <= cyc + 1;

  // Behavioural TCM: grant is combinational, data/valid one cycle later.
  logic [31:0] mem [0:1023];
  bit          grant_en = 1'b1;
  bit          inject_valid = 1'b0;
  assign tcm_grant = tcm_request && grant_en;

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] <= 32'h0;
    tcm_valid     <= 1'b0;
    tcm_read_data <= 32'h0;
  end

  always @(posedge aclk) begin
    tcm_valid <= (tcm_request && tcm_grant) || inject_valid;
    if (tcm_request && tcm_grant) begin
      tcm_read_data <= mem[tcm_address[11:2]];
      if (tcm_write_enable)
        for (int b = 0; b < 4; b++)
          if (tcm_byte_enable[b]) mem[tcm_address[11:2]][8*b +: 8] <= tcm_write_data[8*b +: 8];
    end
  end

  // Reference model: flat byte memory, accesses described as byte counts.
  bit [7:0] ref_mem [0:4095];

  function automatic int nbytes(input logic [1:0] sz);
    return 1 << sz;
  endfunction

  function automatic bit ref_misaligned(input logic [31:0] a, input logic [1:0] sz);
    return (sz == 2'b11) || ((a % nbytes(sz)) != 0);
  endfunction

  function automatic logic [3:0] ref_be(input logic [31:0] a, input logic [1:0] sz);
    logic [3:0] be = 4'b0000;
    for (int i = 0; i < nbytes(sz); i++) be[(a + i) % 4] = 1'b1;
    return be;
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [31:0] wd, input logic [1:0] sz);
    logic [31:0] r = 32'h0;
    for (int k = 0; k < 4; k++) r[8*k +: 8] = wd[8*(k % nbytes(sz)) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [1:0] sz,
                                           input bit sg);
    longint v = 0;
    int     n = nbytes(sz);
    for (int i = 0; i < n; i++) v = v + (longint'(ref_mem[a[11:0] + i]) << (8 * i));
    if (sg && n < 4 && v >= (longint'(1) << (8 * n - 1))) v = v - (longint'(1) << (8 * n));
    return v[31:0];
  endfunction

  function automatic void ref_store(input logic [31:0] a, input logic [1:0] sz,
                                    input logic [31:0] wd);
    for (int i = 0; i < nbytes(sz); i++) ref_mem[a[11:0] + i] = wd[8*i +: 8];
  endfunction

  // Runs one access with resp_ready high; reports what the DUT showed.
  task automatic drive(input logic [31:0] a, input logic we, input logic [1:0] sz,
                       input logic sg, input logic [31:0] wd,
                       output logic treq, output logic [3:0] be, output logic [31:0] twd,
                       output logic rdy, output int lat, output logic [31:0] rd,
                       output logic err);
    req_valid = 1'b1; req_addr = a; req_we = we; req_size = sz; req_signed = sg;
    req_wdata = wd;
    #1;
    treq = tcm_request; be = tcm_byte_enable; twd = tcm_write_data; rdy = req_ready;
    @(posedge aclk); #1;
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 8) begin
      @(posedge aclk); #1;
      lat++;
    end
    if (!resp_valid) lat = 99;
    rd = resp_rdata; err = resp_err;
    @(posedge aclk); #1;
  endtask

  logic        o_treq, o_rdy, o_err;
  logic [3:0]  o_be;
  logic [31:0] o_wd, o_rd;
  int          o_lat;

  task automatic test_reset();
    aresetn = 1'b0;
    #3;
    checks += 4;
    if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid got %b want 0", resp_valid); end
    if (resp_err !== 1'b0) begin errors++; $display("FAIL reset_resp_err got %b want 0", resp_err); end
    if (resp_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h want 0", resp_rdata); end
    if (tcm_request !== 1'b0) begin errors++; $display("FAIL reset_tcm_request got %b want 0", tcm_request); end
    repeat (2) @(posedge aclk);
    #1 aresetn = 1'b1;
    @(posedge aclk); #1;
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got %b want 1", req_ready); end
  endtask

  task automatic test_word();
    drive(32'h100, 1'b1, 2'b10, 1'b0, 32'hDEADBEEF, o_treq, o_be, o_wd, o_rdy, o_lat, o_rd, o_err);
    ref_store(32'h100, 2'b10, 32'hDEADBEEF);
    checks += 6;
    if (o_treq !== 1'b1) begin errors++; $display("FAIL sw_request got %b want 1", o_treq); end
    if (o_be !== 4'b1111) begin errors++; $display("FAIL sw_be got %b want 1111", o_be); end
    if (o_wd !== 32'hDEADBEEF) begin errors++; $display("FAIL sw_wdata got %h want deadbeef", o_wd); end
    if (o_lat != 2) begin errors++; $display("FAIL sw_latency got %0d want 2", o_lat); end
    if (o_err !== 1'b0) begin errors++; $display("FAIL sw_err got %b want 0", o_err); end
    if (o_rd !== 32'h0) begin errors++; $display("FAIL sw_rdata got %h want 0", o_rd); end
    drive(32'h100, 1'b0, 2'b10, 1'b0, 32'h0, o_treq, o_be, o_wd, o_rdy, o_lat, o_rd, o_err);
    checks += 3;
    if (o_be !== 4'b0000) begin errors++; $display("FAIL lw_be got %b want 0000", o_be); end
    if (o_lat != 2) begin errors++; $display("FAIL lw_latency got %0d want 2", o_lat); end
    if (o_rd !== 32'hDEADBEEF) begin errors++; $display("FAIL lw_rdata got %h want deadbeef", o_rd); end
  endtask

  task automatic test_byte();
    logic [7:0]  pat [2];
    logic [31:0] exp_s [2];
    logic [31:0] exp_u [2];
    pat[0] = 8'h5A; exp_s[0] = 32'h0000005A; exp_u[0] = 32'h0000005A;
    pat[1] = 8'hA5; exp_s[1] = 32'hFFFFFFA5; exp_u[1] = 32'h000000A5;
    for (int p = 0; p < 2; p++) begin
      drive(32'h103, 1'b1, 2'b00, 1'b0, {24'h0, pat[p]}, o_treq, o_be, o_wd, o_rdy, o_lat,
            o_rd, o_err);
      ref_store(32'h103, 2'b00, {24'h0, pat[p]});
      checks += 2;
      if (o_be !== 4'b1000) begin errors++; $display("FAIL sb_be got %b want 1000", o_be); end
      if (o_wd !== {4{pat[p]}}) begin errors++; $display("FAIL sb_wdata got %h want %h", o_wd, {4{pat[p]}}); end
      drive(32'h103, 1'b0, 2'b00, 1'b1, 32'h0, o_treq, o_be, o_wd, o_rdy, o_lat, o_rd, o_err);
      checks++;
      if (o_rd !== exp_s[p]) begin errors++; $display("FAIL lb_signed got %h want %h", o_rd, exp_s[p]); end
      drive(32'h103, 1'b0, 2'b00, 1'b0, 32'h0, o_treq, o_be, o_wd, o_rdy, o_lat, o_rd, o_err);
      checks++;
      if (o_rd !== exp_u[p]) begin errors++; $display("FAIL lb_unsigned got %h want %h", o_rd, exp_u[p]); end
    end
  endtask

  task automatic test_half();
    drive(32'h102, 1'b1, 2'b01, 1'b0, 32'h00008001, o_treq, o_be, o_wd, o_rdy, o_lat, o_rd, o_err);
    ref_store(32'h102, 2'b01, 32'h00008001);
    checks += 2;
    if (o_be !== 4'b1100) begin errors++; $display("FAIL sh_be got %b want 1100", o_be); end
    if (o_wd !== 32'h80018001) begin errors++; $display("FAIL sh_wdata got %h want 80018001", o_wd); end
    drive(32'h102, 1'b0, 2'b01, 1'b1, 32'h0, o_treq, o_be, o_wd, o_rdy, o_lat, o_rd, o_err);
    checks++;
    if (o_rd !== 32'hFFFF8001) begin errors++; $display("FAIL lh_signed got %h want ffff8001", o_rd); end
  endtask

  task automatic test_misaligned();
    logic [31:0] addrs [3];
    logic [1:0]  sizes [3];
    addrs[0] = 32'h101; sizes[0] = 2'b01;
    addrs[1] = 32'h102; sizes[1] = 2'b10;
    addrs[2] = 32'h000; sizes[2] = 2'b11;
    for (int i = 0; i < 3; i++) begin
      drive(addrs[i], 1'b0, sizes[i], 1'b0, 32'h0, o_treq, o_be, o_wd, o_rdy, o_lat, o_rd, o_err);
      checks += 4;
      if (o_treq !== 1'b0) begin errors++; $display("FAIL mis%0d_request got %b want 0", i, o_treq); end
      if (o_err !== 1'b1) begin errors++; $display("FAIL mis%0d_err got %b want 1", i, o_err); end
      if (o_rd !== 32'h0) begin errors++; $display("FAIL mis%0d_rdata got %h want 0", i, o_rd); end
      if (o_lat != 1) begin errors++; $display("FAIL mis%0d_latency got %0d want 1", i, o_lat); end
    end
  endtask

  task automatic test_out_of_range();
    grant_en = 1'b0;
    drive(32'h100, 1'b0, 2'b10, 1'b0, 32'h0, o_treq, o_be, o_wd, o_rdy, o_lat, o_rd, o_err);
    grant_en = 1'b1;
    checks += 3;
    if (o_err !== 1'b1) begin errors++; $display("FAIL oor_err got %b want 1", o_err); end
    if (o_lat != 1) begin errors++; $display("FAIL oor_latency got %0d want 1", o_lat); end
    if (o_rd !== 32'h0) begin errors++; $display("FAIL oor_rdata got %h want 0", o_rd); end
    drive(32'h100, 1'b0, 2'b10, 1'b0, 32'h0, o_treq, o_be, o_wd, o_rdy, o_lat, o_rd, o_err);
    checks += 2;
    if (o_err !== 1'b0 || o_lat != 2) begin errors++; $display("FAIL oor_next got err=%b lat=%0d want err=0 lat=2", o_err, o_lat); end
    if (o_rd !== ref_load(32'h100, 2'b10, 1'b0)) begin errors++; $display("FAIL oor_next_rdata got %h want %h", o_rd, ref_load(32'h100, 2'b10, 1'b0)); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 300; n++) begin
      logic [31:0] a  = $urandom_range(0, 4095);
      logic [1:0]  sz = 2'($urandom_range(0, 3));
      logic        we = 1'($urandom);
      logic        sg = 1'($urandom);
      logic [31:0] wd = $urandom;
      bit          mis, oor, e_err;
      if (sz != 2'b11 && $urandom_range(0, 3) != 0) a = a & ~(32'(nbytes(sz)) - 1);
      grant_en = ($urandom_range(0, 7) != 0);
      mis   = ref_misaligned(a, sz);
      oor   = !mis && !grant_en;
      e_err = mis || oor;
      drive(a, we, sz, sg, wd, o_treq, o_be, o_wd, o_rdy, o_lat, o_rd, o_err);
      checks += 5;
      if (o_rdy !== 1'b1) begin errors++; $display("FAIL rnd_ready n=%0d got %b want 1", n, o_rdy); end
      if (o_treq !== !mis) begin errors++; $display("FAIL rnd_request n=%0d a=%h sz=%0d got %b want %b", n, a, sz, o_treq, !mis); end
      if (o_err !== e_err) begin errors++; $display("FAIL rnd_err n=%0d a=%h sz=%0d got %b want %b", n, a, sz, o_err, e_err); end
      if (o_lat != (e_err ? 1 : 2)) begin errors++; $display("FAIL rnd_latency n=%0d got %0d want %0d", n, o_lat, e_err ? 1 : 2); end
      if (!e_err && !we) begin
        if (o_rd !== ref_load(a, sz, sg)) begin errors++; $display("FAIL rnd_load n=%0d a=%h sz=%0d s=%b got %h want %h", n, a, sz, sg, o_rd, ref_load(a, sz, sg)); end
      end else begin
        if (o_rd !== 32'h0) begin errors++; $display("FAIL rnd_rdata_zero n=%0d got %h want 0", n, o_rd); end
      end
      if (!mis && we) begin
        checks += 2;
        if (o_be !== ref_be(a, sz)) begin errors++; $display("FAIL rnd_be n=%0d got %b want %b", n, o_be, ref_be(a, sz)); end
        if (o_wd !== ref_wdata(wd, sz)) begin errors++; $display("FAIL rnd_wdata n=%0d got %h want %h", n, o_wd, ref_wdata(wd, sz)); end
      end
      if (!e_err && we) ref_store(a, sz, wd);
    end
    grant_en = 1'b1;
  endtask

  task automatic test_back_to_back();
    int start;
    start = cyc;
    for (int i = 0; i < 6; i++) begin
      drive(32'h200 + 32'(4 * i), 1'b1, 2'b10, 1'b0, 32'(i * 32'h01010101), o_treq, o_be, o_wd,
            o_rdy, o_lat, o_rd, o_err);
      ref_store(32'h200 + 32'(4 * i), 2'b10, 32'(i * 32'h01010101));
    end
    checks++;
    if (cyc - start != 18) begin errors++; $display("FAIL b2b_cycles got %0d want 18", cyc - start); end
    drive(32'h214, 1'b0, 2'b10, 1'b0, 32'h0, o_treq, o_be, o_wd, o_rdy, o_lat, o_rd, o_err);
    checks++;
    if (o_rd !== 32'h05050505) begin errors++; $display("FAIL b2b_readback got %h want 05050505", o_rd); end
  endtask

  task automatic test_backpressure_reset();
    logic [31:0] exp;
    exp = ref_load(32'h100, 2'b10, 1'b0);
    resp_ready = 1'b0;
    req_valid = 1'b1; req_addr = 32'h100; req_we = 1'b0; req_size = 2'b10; req_signed = 1'b0;
    @(posedge aclk); #1;
    req_addr = 32'h0;  // still valid, must be ignored outside IDLE
    #1;
    checks += 2;
    if (req_ready !== 1'b0) begin errors++; $display("FAIL bp_wait_ready got %b want 0", req_ready); end
    if (tcm_request !== 1'b0) begin errors++; $display("FAIL bp_wait_request got %b want 0", tcm_request); end
    @(posedge aclk); #1;
    for (int i = 0; i < 5; i++) begin
      checks += 4;
      if (resp_valid !== 1'b1) begin errors++; $display("FAIL bp_valid c%0d got %b want 1", i, resp_valid); end
      if (resp_rdata !== exp) begin errors++; $display("FAIL bp_rdata c%0d got %h want %h", i, resp_rdata, exp); end
      if (req_ready !== 1'b0) begin errors++; $display("FAIL bp_ready c%0d got %b want 0", i, req_ready); end
      if (tcm_request !== 1'b0) begin errors++; $display("FAIL bp_request c%0d got %b want 0", i, tcm_request); end
      @(posedge aclk); #1;
    end
    req_valid = 1'b0;
    resp_ready = 1'b1;
    @(posedge aclk); #1;
    checks++;
    if (resp_valid !== 1'b0) begin errors++; $display("FAIL bp_release got %b want 0", resp_valid); end

    // Reset while WAIT: the response is dropped and the late TCM valid ignored.
    req_valid = 1'b1; req_addr = 32'h100;
    @(posedge aclk); #1;
    req_valid = 1'b0;
    aresetn = 1'b0;
    #1;
    checks += 2;
    if (resp_valid !== 1'b0) begin errors++; $display("FAIL rst_wait_valid got %b want 0", resp_valid); end
    if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_wait_ready got %b want 1", req_ready); end
    #2 aresetn = 1'b1;
    @(posedge aclk); #1;
    inject_valid = 1'b1;
    @(posedge aclk); #1;
    inject_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (resp_valid !== 1'b0) begin errors++; $display("FAIL rst_late_valid c%0d got %b want 0", i, resp_valid); end
      @(posedge aclk); #1;
    end
  endtask

  initial begin
    test_reset();
    test_word();
    test_byte();
    test_half();
    test_misaligned();
    test_out_of_range();
    test_back_to_back();
    test_backpressure_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
